alu_issue_queue: RTL

- Parametrised successor to the single-register ALU operand/op selector: decodes RV32I opcode/funct3/funct7 into ALU operands and op, then buffers results in a small FIFO with valid/ready handshakes on both sides.
- Adds x0 zeroing, writeback forwarding, shift-amount masking and illegal-encoding detection.
- Sits between the decode/register-read stage and the ALU.

---
 rtl/alu_issue_queue.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
// RV32I decode into ALU operands/op, buffered in a small FIFO with valid/ready on both sides.
// Adds x0 zeroing, writeback forwarding, shift-amount masking and illegal-encoding detection.
package alu_issue_queue_pkg;
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
endpackage

module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  opcode_t               opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] current_pc,
  input  logic                  fwd_en,
  input  logic [4:0]            fwd_rd,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output alu_op_t               alu_op,
  output logic                  out_illegal
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // DATA_WIDTH is a power of two, so DATA_WIDTH-1 is exactly the shift-amount mask.
  localparam logic [DATA_WIDTH-1:0] SHAMT_MASK = DATA_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      FULL       = CNT_W'(DEPTH);
  localparam logic [6:0]            F7_ZERO    = 7'b0000000;
  localparam logic [6:0]            F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    alu_op_t               op;
    logic                  illegal;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop, dec_ill;
  logic [DATA_WIDTH-1:0] src1, src2;
  entry_t                dec, head;

  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [4:0] addr, input logic [DATA_WIDTH-1:0] data,
    input logic f_en, input logic [4:0] f_rd, input logic [DATA_WIDTH-1:0] f_data);
    if (addr == 5'd0)                      return '0;
    else if (FWD_EN && f_en && f_rd == addr) return f_data;
    else                                   return data;
  endfunction

  function automatic alu_op_t f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    src1 = resolve(rs1_addr, rs1_data, fwd_en, fwd_rd, fwd_data);
    src2 = resolve(rs2_addr, rs2_data, fwd_en, fwd_rd, fwd_data);
  end

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op1 = src1;
        dec.op2 = src2;
        dec.op  = f3_op(funct3, funct7 == F7_ALT);
        if (funct7 == F7_ALT) dec_ill = !(funct3 == 3'b000 || funct3 == 3'b101);
        else                  dec_ill = (funct7 != F7_ZERO);
      end
      OPC_OP_IMM: begin
        dec.op1 = src1;
        dec.op2 = imm;
        dec.op  = f3_op(funct3, funct3 == 3'b101 && funct7[5]);
        if (funct3 == 3'b001)      dec_ill = (funct7 != F7_ZERO);
        else if (funct3 == 3'b101) dec_ill = !(funct7 == F7_ZERO || funct7 == F7_ALT);
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec.op1 = src1;
        dec.op2 = imm;
      end
      OPC_BRANCH: begin
        dec.op1 = src1;
        dec.op2 = src2;
        case (funct3[2:1])
          2'b00:   dec.op = ALU_SUB;
          2'b01:   dec_ill = 1'b1;
          2'b10:   dec.op = ALU_SLT;
          default: dec.op = ALU_SLTU;
        endcase
      end
      OPC_LUI:           dec.op2 = imm;
      OPC_AUIPC, OPC_JAL: begin
        dec.op1 = current_pc;
        dec.op2 = imm;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        dec.op1 = src1;
        dec.op2 = src2;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec.op inside {ALU_SLL, ALU_SRL, ALU_SRA}) dec.op2 = dec.op2 & SHAMT_MASK;
    if (dec_ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // in_ready depends only on registered count: a pop never frees a slot for the same cycle.
  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign alu_operand1 = head.op1;
  assign alu_operand2 = head.op2;
  assign alu_op       = head.op;
  assign out_illegal  = head.illegal;
endmodule
